regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL: parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL: parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W.
REQ-003 SHALL: parameter NRD, default 2, number of read ports; legal range 1..4.
REQ-004 SHALL: port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL: port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL: ports we0, waddr0, wdata0, inputs, 1/ADDR_W/DATA_W, write port 0 (execute result).
REQ-007 SHALL: ports we1, waddr1, wdata1, inputs, 1/ADDR_W/DATA_W, write port 1 (late/load result).
REQ-008 SHALL: port re, input, NRD, per-port read enable.
REQ-009 SHALL: port raddr, input, NRD*ADDR_W, packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL: port rdata, output, NRD*DATA_W, packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-011 SHALL: port rbusy, output, NRD, per-port "operand pending" flag.
REQ-012 SHALL: ports set_en and set_addr, inputs, 1/ADDR_W, scoreboard reservation of a destination register.
REQ-013 SHALL: port flush, input, 1, synchronous clear of all busy bits.
REQ-014 SHALL: port ready, output, 1, high when initialisation is complete and the file accepts writes.

Function
REQ-015 SHALL: the FSM has two states, INIT and RUN; reset enters INIT with sweep counter = 0.
REQ-016 SHALL: in INIT, the block writes zero to the register at the counter address each cycle and increments the counter; after the cycle that clears address 2**ADDR_W-1, the FSM moves to RUN, so INIT lasts exactly 2**ADDR_W cycles.
REQ-017 SHALL: in INIT, we0, we1, set_en and flush are ignored; ready=0, rdata=0 and rbusy=0.
REQ-018 SHALL: in RUN, ready=1 and the FSM stays in RUN until reset.
REQ-019 SHALL: in RUN, we0 or we1 with a nonzero address updates that register at the clock edge; writes to address 0 are discarded.
REQ-020 SHALL: when we0 and we1 target the same address in the same cycle, port 1 data is written.
REQ-021 SHALL: rdata for port i is combinational, evaluated in this order:
- 0 if re[i]=0 or raddr_i=0;
- else wdata1 if we1 and waddr1==raddr_i;
- else wdata0 if we0 and waddr0==raddr_i;
- else the stored value.
REQ-022 SHALL: each nonzero register has a busy bit; set_en sets busy[set_addr] and any accepted write clears busy[waddr].
REQ-023 SHALL: if a write and set_en target the same address in one cycle, busy ends set (the new producer wins).
REQ-024 SHALL: flush clears all busy bits, then set_en applies in the same cycle.
REQ-025 SHALL: busy[0] is constant 0.
REQ-026 SHALL: rbusy[i] = re[i] and busy[raddr_i] and no same-cycle write (either port) to raddr_i; a bypassed operand is never reported busy.
REQ-027 SHALL: any number of read ports may read the same address in the same cycle without conflict.

Reset
REQ-028 SHALL: while rst=0, ready=0, the FSM is in INIT with counter 0, all busy bits are 0, and rdata and rbusy are 0; register contents are undefined until the sweep completes.
REQ-029 SHALL: rst asserted mid-sweep or in RUN aborts immediately, and the full sweep restarts after deassertion.

Verification
REQ-030 SHALL: bench releases reset, reads all addresses at cycle 33 -> ready rises exactly 32 cycles after release (ADDR_W=5) and every read returns 0.
REQ-031 SHALL: in RUN, we0 to x3 with 0x11111111 and we1 to x3 with 0x22222222 in the same cycle, with raddr0=3 -> rdata0=0x22222222 that cycle and x3 holds 0x22222222 the next cycle.
REQ-032 SHALL: set_en to x7, then read x7 -> rbusy=1; in a cycle with we0 to x7 = 0x5 -> rdata=0x5 and rbusy=0; the following cycle rbusy=0.
REQ-033 SHALL: write x0=0xFFFFFFFF, with set_en at addr 0 -> reads of x0 return 0 and rbusy=0.
REQ-034 SHALL: set busy on x4 and x9, then flush together with set_en x9 -> the next cycle busy[4]=0 and busy[9]=1.
REQ-035 SHALL: assert rst for 1 cycle mid-RUN -> ready=0 immediately and returns to 1 exactly 32 cycles after release; busy bits are clear and we0 is ignored during INIT.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, NRD bypassed read ports,
// a per-register busy scoreboard and a zeroing sweep after every reset.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  flush,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_sweepCnt;
    logic                r_ready;
    logic [DATA_W-1:0]   r_regs [DEPTH];
    logic [DEPTH-1:0]    r_busy;

    logic                w_we0Ok;
    logic                w_we1Ok;
    logic [DEPTH-1:0]    w_busyNext;

    // Writes are only honoured once the sweep is done; x0 is hardwired to zero.
    assign w_we0Ok = r_ready && we0 && (waddr0 != '0);
    assign w_we1Ok = r_ready && we1 && (waddr1 != '0);
    assign ready   = r_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_sweepCnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_sweepCnt <= r_sweepCnt + 1'b1;
                    if (r_sweepCnt == {ADDR_W{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep zeroes it. Port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_regs[r_sweepCnt] <= '0;
        end else begin
            if (w_we0Ok) begin
                r_regs[waddr0] <= wdata0;
            end
            if (w_we1Ok) begin
                r_regs[waddr1] <= wdata1;
            end
        end
    end

    // Flush first, then retire completed writes, then a new reservation overrides both.
    always_comb begin
        w_busyNext = r_busy;
        if (r_ready) begin
            if (flush) begin
                w_busyNext = '0;
            end
            if (w_we0Ok) begin
                w_busyNext[waddr0] = 1'b0;
            end
            if (w_we1Ok) begin
                w_busyNext[waddr1] = 1'b0;
            end
            if (set_en) begin
                w_busyNext[set_addr] = 1'b1;
            end
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic              w_rdEn;
        logic              w_hit0;
        logic              w_hit1;

        assign w_raddr = raddr[g*ADDR_W +: ADDR_W];
        assign w_rdEn  = r_ready && re[g] && (w_raddr != '0);
        assign w_hit0  = w_we0Ok && (waddr0 == w_raddr);
        assign w_hit1  = w_we1Ok && (waddr1 == w_raddr);

        assign rdata[g*DATA_W +: DATA_W] = !w_rdEn ? '0     :
                                           w_hit1  ? wdata1 :
                                           w_hit0  ? wdata0 :
                                                     r_regs[w_raddr];
        // An operand being written this cycle is forwarded, so it is never pending.
        assign rbusy[g] = w_rdEn && r_busy[w_raddr] && !w_hit0 && !w_hit1;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

    logic        clk;
    logic        rst;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        flush;
    logic        ready;

    typedef struct {
        string       name;
        logic        expReady;
        logic [63:0] expRdata;
        logic [1:0]  expRbusy;
    } exp_t;

    exp_t expQ[$];
    int   vecCount  = 0;
    int   missCount = 0;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .waddr0   (waddr0),
        .wdata0   (wdata0),
        .we1      (we1),
        .waddr1   (waddr1),
        .wdata1   (wdata1),
        .re       (re),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .set_en   (set_en),
        .set_addr (set_addr),
        .flush    (flush),
        .ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, vectors=%0d", vecCount);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input string name, input logic rstV,
                                 input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic [1:0] reV, input logic [4:0] r0, input logic [4:0] r1,
                                 input logic sEn, input logic [4:0] sA, input logic fl,
                                 input logic eRdy, input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [1:0] eBusy);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = rstV;
        we0      = w0;
        waddr0   = a0;
        wdata0   = d0;
        we1      = w1;
        waddr1   = a1;
        wdata1   = d1;
        re       = reV;
        raddr    = {r1, r0};
        set_en   = sEn;
        set_addr = sA;
        flush    = fl;
        e.name     = name;
        e.expReady = eRdy;
        e.expRdata = {e1, e0};
        e.expRbusy = eBusy;
        expQ.push_back(e);
    endtask

    task automatic runVec(input string name,
                          input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [1:0] reV, input logic [4:0] r0, input logic [4:0] r1,
                          input logic sEn, input logic [4:0] sA, input logic fl,
                          input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eBusy);
        applyStimulus(name, 1'b1, w0, a0, d0, w1, a1, d1, reV, r0, r1, sEn, sA, fl,
                      1'b1, e0, e1, eBusy);
    endtask

    task automatic checkOutput(input exp_t e);
        vecCount++;
        if (ready !== e.expReady || rdata !== e.expRdata || rbusy !== e.expRbusy) begin
            missCount++;
            $display("[TB] FAIL %s: got ready=%0b rdata=%h rbusy=%b, expected ready=%0b rdata=%h rbusy=%b",
                     e.name, ready, rdata, rbusy, e.expReady, e.expRdata, e.expRbusy);
        end
    endtask

    // Each queued expectation describes the outputs of the cycle it was issued in.
    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        rst = 1'b0; we0 = 1'b0; waddr0 = '0; wdata0 = '0; we1 = 1'b0; waddr1 = '0;
        wdata1 = '0; re = '0; raddr = '0; set_en = 1'b0; set_addr = '0; flush = 1'b0;

        for (int k = 0; k < 3; k++) begin
            applyStimulus($sformatf("in_reset_%0d", k), 1'b0, 1'b1, 5'd3, 32'hDEAD0003,
                          1'b1, 5'd3, 32'hDEAD1003, 2'b11, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0,
                          1'b0, 32'h0, 32'h0, 2'b00);
        end

        for (int k = 0; k < 32; k++) begin
            logic [4:0] a;
            a = (k == 0) ? 5'd0 : 5'(k - 1);
            applyStimulus($sformatf("init_k%0d", k), 1'b1, 1'b1, a, 32'hBAD00000 | k,
                          1'b1, a, 32'hBEEF0000 | k, 2'b11, a, 5'(k), 1'b1, a, 1'b0,
                          1'b0, 32'h0, 32'h0, 2'b00);
        end

        for (int a = 0; a < 32; a++) begin
            runVec($sformatf("sweep_read_%0d", a), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   2'b11, 5'(a), 5'(31 - a), 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 2'b00);
        end

        runVec("dual_write_x1x2", 1, 5'd1, 32'hA5A5A5A5, 1, 5'd2, 32'h5A5A5A5A, 2'b11, 5'd1, 5'd2, 0, 5'd0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00);
        runVec("readback_x1x2",   0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd1, 5'd2, 0, 5'd0, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'b00);
        runVec("same_addr_x3",    1, 5'd3, 32'h11111111, 1, 5'd3, 32'h22222222, 2'b01, 5'd3, 5'd3, 0, 5'd0, 0, 32'h22222222, 32'h0,        2'b00);
        runVec("held_x3",         0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd3, 5'd1, 0, 5'd0, 0, 32'h22222222, 32'hA5A5A5A5, 2'b00);
        runVec("set_x7",          0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b00, 5'd7, 5'd7, 1, 5'd7, 0, 32'h0,        32'h0,        2'b00);
        runVec("busy_x7",         0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b01, 5'd7, 5'd0, 0, 5'd0, 0, 32'h0,        32'h0,        2'b01);
        runVec("bypass_x7",       1, 5'd7, 32'h5,        0, 5'd0, 32'h0,        2'b11, 5'd7, 5'd7, 0, 5'd0, 0, 32'h5,        32'h5,        2'b00);
        runVec("after_x7",        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd7, 5'd7, 0, 5'd0, 0, 32'h5,        32'h5,        2'b00);
        runVec("zero_write",      1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 32'hFFFFFFFF, 2'b11, 5'd0, 5'd0, 1, 5'd0, 0, 32'h0,        32'h0,        2'b00);
        runVec("zero_after",      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd0, 5'd3, 0, 5'd0, 0, 32'h0,        32'h22222222, 2'b00);
        runVec("write_set_x5",    1, 5'd5, 32'h123,      0, 5'd0, 32'h0,        2'b01, 5'd5, 5'd0, 1, 5'd5, 0, 32'h123,      32'h0,        2'b00);
        runVec("x5_busy",         0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd5, 5'd5, 0, 5'd0, 0, 32'h123,      32'h123,      2'b11);
        runVec("x5_we1_bypass",   0, 5'd0, 32'h0,        1, 5'd5, 32'h456,      2'b11, 5'd5, 5'd2, 0, 5'd0, 0, 32'h456,      32'h5A5A5A5A, 2'b00);
        runVec("x5_cleared",      0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b01, 5'd5, 5'd0, 0, 5'd0, 0, 32'h456,      32'h0,        2'b00);
        runVec("set_x4",          0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b00, 5'd0, 5'd0, 1, 5'd4, 0, 32'h0,        32'h0,        2'b00);
        runVec("set_x9",          0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b01, 5'd4, 5'd0, 1, 5'd9, 0, 32'h0,        32'h0,        2'b01);
        runVec("flush_set_x9",    0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd4, 5'd9, 1, 5'd9, 1, 32'h0,        32'h0,        2'b11);
        runVec("after_flush",     0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd4, 5'd9, 0, 5'd0, 0, 32'h0,        32'h0,        2'b10);
        runVec("re_gated",        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b00, 5'd9, 5'd9, 0, 5'd0, 0, 32'h0,        32'h0,        2'b00);
        runVec("we0_bypass_x12",  1, 5'd12, 32'h77,      0, 5'd0, 32'h0,        2'b11, 5'd12, 5'd9, 0, 5'd0, 0, 32'h77,      32'h0,        2'b10);
        runVec("set_x4_wr_x6",    0, 5'd0, 32'h0,        1, 5'd6, 32'hCAFEF00D, 2'b00, 5'd0, 5'd0, 1, 5'd4, 0, 32'h0,        32'h0,        2'b00);
        runVec("pre_reset",       0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd4, 5'd6, 0, 5'd0, 0, 32'h0,        32'hCAFEF00D, 2'b01);

        applyStimulus("reset_pulse", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                      2'b11, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);

        for (int k = 0; k < 32; k++) begin
            applyStimulus($sformatf("reinit_k%0d", k), 1'b1, 1'b1, 5'd6, 32'hDEADBEEF,
                          1'b0, 5'd0, 32'h0, 2'b11, 5'd6, 5'd9, 1'b1, 5'd8, 1'b0,
                          1'b0, 32'h0, 32'h0, 2'b00);
        end

        runVec("post_reset_x6x9", 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd6, 5'd9, 0, 5'd0, 0, 32'h0,        32'h0,        2'b00);
        runVec("post_reset_x8x4", 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd8, 5'd4, 0, 5'd0, 0, 32'h0,        32'h0,        2'b00);
        runVec("post_reset_x1",   0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b11, 5'd1, 5'd12, 0, 5'd0, 0, 32'h0,       32'h0,        2'b00);
        runVec("post_reset_wr",   1, 5'd6, 32'h1234,     0, 5'd0, 32'h0,        2'b11, 5'd6, 5'd3, 0, 5'd0, 0, 32'h1234,     32'h0,        2'b00);
        runVec("post_reset_rd",   0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        2'b01, 5'd6, 5'd0, 0, 5'd0, 0, 32'h1234,     32'h0,        2'b00);

        @(negedge clk);
        @(negedge clk);
        vecCount++;
        if (expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL queue_drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
